bpu_resolve_queue: RTL and testbench

- Sits between the branch predictor (fetch side) and the execute stage.
- Buffers per-instruction prediction metadata in program order. At execute resolution it pops the head entry and compares the prediction against the real outcome.
- Drives the predictor's update interface (update_en, pc_ex, mis_pdc, npc_ex, kind_ex, taken_real, bh_ex, choice_real, choice_pdc_ex, out_pdch), and drives a redirect/flush when the predicted next PC is wrong.

---
 rtl/bpu_pkg.sv | 52 +++++
 rtl/bpu_rq_fifo.sv | 85 ++++++++
 rtl/bpu_resolve_queue.sv | 240 ++++++++++++++++++++++++
 tb/tb_bpu_resolve_queue.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// -----------------------------------------------------------------------------
// bpu_pkg
// Constants and types shared by the branch-prediction resolve queue.
//   - bpu_kind_e   : branch kind encoding used by predictor and execute
//   - MIS_*        : bit positions inside the 3-bit mis_pdc vector
//   - PDCH_*       : field offsets inside the 8-bit hysteresis bundle
//   - rq_entry_t   : queue entry layout at the default widths
// -----------------------------------------------------------------------------
package bpu_pkg;

  typedef enum logic [2:0] {
    KIND_NOT_JUMP      = 3'd0,
    KIND_DIRECT_JUMP   = 3'd1,
    KIND_RET           = 3'd4,
    KIND_INDIRECT_JUMP = 3'd5,
    KIND_CALL          = 3'd6,
    KIND_JUMP          = 3'd7
  } bpu_kind_e;

  // mis_pdc = {npc wrong, kind wrong, taken wrong}
  localparam int MIS_NPC   = 2;
  localparam int MIS_KIND  = 1;
  localparam int MIS_TAKEN = 0;

  // pdch = {taken_g[1:0], taken_b[1:0], choice_btb_ras[1:0], choice_b_g[1:0]}
  localparam int PDCH_TAKEN_G_LSB    = 6;
  localparam int PDCH_TAKEN_G_MSB    = 7;
  localparam int PDCH_TAKEN_B_LSB    = 4;
  localparam int PDCH_TAKEN_B_MSB    = 5;
  localparam int PDCH_CHOICE_BR_LSB  = 2;
  localparam int PDCH_CHOICE_BG_LSB  = 0;

  // choice = {btb_ras, b_g}
  localparam int CHOICE_B_G     = 0;
  localparam int CHOICE_BTB_RAS = 1;

  localparam int DEF_ADDR_WIDTH = 30;
  localparam int DEF_H_WIDTH    = 14;

  // Entry layout at the default widths; the top rebuilds the same field
  // order with its own parameter widths so non-default configurations work.
  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] pc;
    logic [DEF_ADDR_WIDTH-1:0] npc;
    logic [2:0]                kind;
    logic                      taken;
    logic [DEF_H_WIDTH-1:0]    bh;
    logic [1:0]                choice;
    logic [7:0]                pdch;
  } rq_entry_t;

endpackage

// File: rtl/bpu_rq_fifo.sv
// -----------------------------------------------------------------------------
// bpu_rq_fifo
// Circular buffer holding prediction entries in program order.
//   clk, rstn  : clock, synchronous active-low reset
//   clear_i    : empty the buffer (wins over push and pop)
//   push_i     : write data_i at the tail (ignored when full)
//   pop_i      : retire the head entry (ignored when empty)
//   data_i     : entry to write
//   head_o     : head entry, combinational read
//   count_o    : number of valid entries (0..DEPTH)
//   full_o     : count_o == DEPTH
//   empty_o    : count_o == 0
// -----------------------------------------------------------------------------
module bpu_rq_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o && !clear_i;
  assign pop_ok  = pop_i  && !empty_o && !clear_i;

  // NOTE: every variable gets its default at the top of the block so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      // Emptying by catching the read pointer up keeps the write pointer,
      // so no stale data is exposed and nothing needs rewriting.
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; an entry is only read after it
  // has been written, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/bpu_resolve_queue.sv
// -----------------------------------------------------------------------------
// bpu_resolve_queue
// Holds per-instruction prediction metadata between fetch and execute. When
// execute resolves the oldest instruction, the head entry is compared with
// the real outcome, the predictor update bundle is registered, and a
// redirect is raised if the predicted next PC was wrong.
//   clk, rstn               : clock, synchronous active-low reset
//   flush_in                : empties the queue, suppresses a concurrent pop
//   push_*                  : prediction from the fetch side (valid/ready)
//   res_*                   : resolution of the oldest instruction
//   update_en + *_ex, mis_pdc, taken_real, choice_real, out_pdch
//                           : registered predictor update, 1 cycle after res
//   redirect_valid/_pc      : registered one-cycle redirect on npc mismatch
//   err_underflow           : sticky, res_valid seen with an empty queue
// -----------------------------------------------------------------------------
module bpu_resolve_queue
  import bpu_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 30,
  parameter int H_WIDTH    = 14
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush_in,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [ADDR_WIDTH-1:0] push_pc,
  input  logic [ADDR_WIDTH-1:0] push_npc,
  input  logic [2:0]            push_kind,
  input  logic                  push_taken,
  input  logic [H_WIDTH-1:0]    push_bh,
  input  logic [1:0]            push_choice,
  input  logic [7:0]            push_pdch,
  input  logic                  res_valid,
  input  logic [2:0]            res_kind,
  input  logic                  res_taken,
  input  logic [ADDR_WIDTH-1:0] res_target,
  input  logic [ADDR_WIDTH-1:0] res_ret_pc,
  output logic                  update_en,
  output logic [ADDR_WIDTH-1:0] pc_ex,
  output logic [ADDR_WIDTH-1:0] npc_ex,
  output logic [ADDR_WIDTH-1:0] ret_pc_ex,
  output logic [2:0]            kind_ex,
  output logic                  taken_real,
  output logic [H_WIDTH-1:0]    bh_ex,
  output logic [2:0]            mis_pdc,
  output logic [1:0]            choice_real,
  output logic [1:0]            choice_pdc_ex,
  output logic [7:0]            out_pdch,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  err_underflow
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Same field order as bpu_pkg::rq_entry_t, sized by this instance.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] npc;
    logic [2:0]            kind;
    logic                  taken;
    logic [H_WIDTH-1:0]    bh;
    logic [1:0]            choice;
    logic [7:0]            pdch;
  } entry_t;

  entry_t                push_entry;
  entry_t                head;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

  logic                  pop_fire;
  logic                  push_fire;
  logic                  npc_wrong;
  logic                  fifo_clear;
  logic                  fifo_pop;
  logic [ADDR_WIDTH-1:0] real_npc;
  logic [2:0]            mis_vec;
  logic                  choice_bg_real;

  assign push_entry = '{pc:     push_pc,
                        npc:    push_npc,
                        kind:   push_kind,
                        taken:  push_taken,
                        bh:     push_bh,
                        choice: push_choice,
                        pdch:   push_pdch};

  assign push_ready = !fifo_full;

  // ---------------------------------------------------------------------------
  // Head comparison
  // ---------------------------------------------------------------------------
  assign real_npc = res_taken ? res_target : head.pc + ADDR_WIDTH'(1);

  always_comb begin
    mis_vec            = '0;
    mis_vec[MIS_NPC]   = (head.npc   != real_npc);
    mis_vec[MIS_KIND]  = (head.kind  != res_kind);
    mis_vec[MIS_TAKEN] = (head.taken != res_taken);
  end

  // Whichever direction counter's strong bit agreed with the outcome wins
  // the chooser; if neither agreed the previous choice stands.
  always_comb begin
    choice_bg_real = head.choice[CHOICE_B_G];
    if (head.pdch[PDCH_TAKEN_G_MSB] == res_taken)      choice_bg_real = 1'b1;
    else if (head.pdch[PDCH_TAKEN_B_MSB] == res_taken) choice_bg_real = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Queue control: flush beats everything; a wrong npc pops the head and
  // throws away all younger (wrong-path) entries plus any same-cycle push.
  // ---------------------------------------------------------------------------
  assign pop_fire   = res_valid && !fifo_empty && !flush_in;
  assign npc_wrong  = pop_fire && mis_vec[MIS_NPC];
  assign fifo_clear = flush_in || npc_wrong;
  assign fifo_pop   = pop_fire && !npc_wrong;
  assign push_fire  = push_valid && !fifo_full && !fifo_clear;

  bpu_rq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .clear_i (fifo_clear),
    .push_i  (push_fire),
    .pop_i   (fifo_pop),
    .data_i  (push_entry),
    .head_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Registered update / redirect stage
  // ---------------------------------------------------------------------------
  logic                  update_en_q, update_en_d;
  logic [ADDR_WIDTH-1:0] pc_ex_q, pc_ex_d;
  logic [ADDR_WIDTH-1:0] npc_ex_q, npc_ex_d;
  logic [ADDR_WIDTH-1:0] ret_pc_ex_q, ret_pc_ex_d;
  logic [2:0]            kind_ex_q, kind_ex_d;
  logic                  taken_real_q, taken_real_d;
  logic [H_WIDTH-1:0]    bh_ex_q, bh_ex_d;
  logic [2:0]            mis_pdc_q, mis_pdc_d;
  logic [1:0]            choice_real_q, choice_real_d;
  logic [1:0]            choice_pdc_q, choice_pdc_d;
  logic [7:0]            pdch_q, pdch_d;
  logic                  redirect_valid_q, redirect_valid_d;
  logic [ADDR_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic                  err_underflow_q, err_underflow_d;

  always_comb begin
    update_en_d      = pop_fire;
    redirect_valid_d = npc_wrong;
    pc_ex_d          = pc_ex_q;
    npc_ex_d         = npc_ex_q;
    ret_pc_ex_d      = ret_pc_ex_q;
    kind_ex_d        = kind_ex_q;
    taken_real_d     = taken_real_q;
    bh_ex_d          = bh_ex_q;
    mis_pdc_d        = mis_pdc_q;
    choice_real_d    = choice_real_q;
    choice_pdc_d     = choice_pdc_q;
    pdch_d           = pdch_q;
    redirect_pc_d    = redirect_pc_q;
    err_underflow_d  = err_underflow_q || (res_valid && fifo_empty);

    // Update fields are held between pops so the predictor can read them
    // at leisure; only update_en is a strobe.
    if (pop_fire) begin
      pc_ex_d       = head.pc;
      npc_ex_d      = real_npc;
      ret_pc_ex_d   = res_ret_pc;
      kind_ex_d     = res_kind;
      taken_real_d  = res_taken;
      bh_ex_d       = head.bh;
      mis_pdc_d     = mis_vec;
      choice_real_d = {(res_kind == KIND_RET), choice_bg_real};
      choice_pdc_d  = head.choice;
      pdch_d        = head.pdch;
    end
    if (npc_wrong) redirect_pc_d = real_npc;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      update_en_q      <= 1'b0;
      pc_ex_q          <= '0;
      npc_ex_q         <= '0;
      ret_pc_ex_q      <= '0;
      kind_ex_q        <= '0;
      taken_real_q     <= 1'b0;
      bh_ex_q          <= '0;
      mis_pdc_q        <= '0;
      choice_real_q    <= '0;
      choice_pdc_q     <= '0;
      pdch_q           <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      err_underflow_q  <= 1'b0;
    end else begin
      update_en_q      <= update_en_d;
      pc_ex_q          <= pc_ex_d;
      npc_ex_q         <= npc_ex_d;
      ret_pc_ex_q      <= ret_pc_ex_d;
      kind_ex_q        <= kind_ex_d;
      taken_real_q     <= taken_real_d;
      bh_ex_q          <= bh_ex_d;
      mis_pdc_q        <= mis_pdc_d;
      choice_real_q    <= choice_real_d;
      choice_pdc_q     <= choice_pdc_d;
      pdch_q           <= pdch_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      err_underflow_q  <= err_underflow_d;
    end
  end

  assign update_en      = update_en_q;
  assign pc_ex          = pc_ex_q;
  assign npc_ex         = npc_ex_q;
  assign ret_pc_ex      = ret_pc_ex_q;
  assign kind_ex        = kind_ex_q;
  assign taken_real     = taken_real_q;
  assign bh_ex          = bh_ex_q;
  assign mis_pdc        = mis_pdc_q;
  assign choice_real    = choice_real_q;
  assign choice_pdc_ex  = choice_pdc_q;
  assign out_pdch       = pdch_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign err_underflow  = err_underflow_q;

endmodule

// File: tb/tb_bpu_resolve_queue.sv
// -----------------------------------------------------------------------------
// tb_bpu_resolve_queue
// Directed bench for bpu_resolve_queue with hand-computed expectations.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_bpu_resolve_queue;

  localparam int AW = 30;
  localparam int HW = 14;

  logic          clk = 1'b0;
  logic          rstn;
  logic          flush_in;
  logic          push_valid;
  logic          push_ready;
  logic [AW-1:0] push_pc, push_npc;
  logic [2:0]    push_kind;
  logic          push_taken;
  logic [HW-1:0] push_bh;
  logic [1:0]    push_choice;
  logic [7:0]    push_pdch;
  logic          res_valid;
  logic [2:0]    res_kind;
  logic          res_taken;
  logic [AW-1:0] res_target, res_ret_pc;
  logic          update_en;
  logic [AW-1:0] pc_ex, npc_ex, ret_pc_ex;
  logic [2:0]    kind_ex;
  logic          taken_real;
  logic [HW-1:0] bh_ex;
  logic [2:0]    mis_pdc;
  logic [1:0]    choice_real, choice_pdc_ex;
  logic [7:0]    out_pdch;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          err_underflow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bpu_resolve_queue #(.DEPTH(8), .ADDR_WIDTH(AW), .H_WIDTH(HW)) dut (
    .clk(clk), .rstn(rstn), .flush_in(flush_in),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_pc(push_pc), .push_npc(push_npc), .push_kind(push_kind),
    .push_taken(push_taken), .push_bh(push_bh), .push_choice(push_choice),
    .push_pdch(push_pdch),
    .res_valid(res_valid), .res_kind(res_kind), .res_taken(res_taken),
    .res_target(res_target), .res_ret_pc(res_ret_pc),
    .update_en(update_en), .pc_ex(pc_ex), .npc_ex(npc_ex),
    .ret_pc_ex(ret_pc_ex), .kind_ex(kind_ex), .taken_real(taken_real),
    .bh_ex(bh_ex), .mis_pdc(mis_pdc), .choice_real(choice_real),
    .choice_pdc_ex(choice_pdc_ex), .out_pdch(out_pdch),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .err_underflow(err_underflow)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush_in    = 1'b0;
    push_valid  = 1'b0;
    push_pc     = '0;
    push_npc    = '0;
    push_kind   = '0;
    push_taken  = 1'b0;
    push_bh     = '0;
    push_choice = '0;
    push_pdch   = '0;
    res_valid   = 1'b0;
    res_kind    = '0;
    res_taken   = 1'b0;
    res_target  = '0;
    res_ret_pc  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
    step();
  endtask

  // Presents push inputs for one clock edge.
  task automatic push_full(input logic [AW-1:0] pc, input logic [AW-1:0] npc,
                           input logic [2:0] kind, input logic taken,
                           input logic [HW-1:0] bh, input logic [1:0] choice,
                           input logic [7:0] pdch);
    push_valid  = 1'b1;
    push_pc     = pc;
    push_npc    = npc;
    push_kind   = kind;
    push_taken  = taken;
    push_bh     = bh;
    push_choice = choice;
    push_pdch   = pdch;
    step();
    push_valid  = 1'b0;
  endtask

  task automatic push(input logic [AW-1:0] pc, input logic [AW-1:0] npc,
                      input logic [2:0] kind, input logic taken);
    push_full(pc, npc, kind, taken, '0, '0, '0);
  endtask

  // Presents a resolution for one clock edge; the registered results are
  // visible when this returns.
  task automatic resolve(input logic [2:0] kind, input logic taken,
                         input logic [AW-1:0] target);
    res_valid  = 1'b1;
    res_kind   = kind;
    res_taken  = taken;
    res_target = target;
    step();
    res_valid  = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();

    // ---- reset state -------------------------------------------------------
    do_reset();
    check("rst_push_ready", 64'(push_ready), 64'(1));
    check("rst_update_en", 64'(update_en), 64'(0));
    check("rst_redirect", 64'(redirect_valid), 64'(0));
    check("rst_err", 64'(err_underflow), 64'(0));
    check("rst_mis_pdc", 64'(mis_pdc), 64'(0));

    // ---- fill to full, overflow push ignored, drain in order ----------------
    for (int i = 0; i < 8; i++) begin
      push(AW'(32'h40 + i * 16), AW'(32'h41 + i * 16), 3'd0, 1'b0);
      check($sformatf("fill_ready_%0d", i), 64'(push_ready), 64'(i < 7 ? 1 : 0));
    end
    push(AW'(32'h999), AW'(32'h99a), 3'd0, 1'b0);
    check("full_ready_held", 64'(push_ready), 64'(0));
    for (int i = 0; i < 8; i++) begin
      resolve(3'd0, 1'b0, '0);
      check($sformatf("drain_upd_%0d", i), 64'(update_en), 64'(1));
      check($sformatf("drain_pc_%0d", i), 64'(pc_ex), 64'(32'h40 + i * 16));
      check($sformatf("drain_mis_%0d", i), 64'(mis_pdc), 64'(0));
    end
    check("drained_ready", 64'(push_ready), 64'(1));
    resolve(3'd0, 1'b0, '0);
    check("overflow_dropped_upd", 64'(update_en), 64'(0));
    check("overflow_dropped_err", 64'(err_underflow), 64'(1));

    // ---- correct not-taken prediction ---------------------------------------
    do_reset();
    push(AW'(32'h100), AW'(32'h101), 3'd0, 1'b0);
    resolve(3'd0, 1'b0, '0);
    check("nt_upd", 64'(update_en), 64'(1));
    check("nt_mis", 64'(mis_pdc), 64'(3'b000));
    check("nt_npc_ex", 64'(npc_ex), 64'(32'h101));
    check("nt_pc_ex", 64'(pc_ex), 64'(32'h100));
    check("nt_redirect", 64'(redirect_valid), 64'(0));
    step();
    check("nt_upd_pulse", 64'(update_en), 64'(0));
    check("nt_npc_hold", 64'(npc_ex), 64'(32'h101));

    // ---- taken mispredict flushes younger entries ----------------------------
    do_reset();
    push(AW'(32'h200), AW'(32'h201), 3'd1, 1'b0);
    push(AW'(32'h300), AW'(32'h301), 3'd0, 1'b0);
    push(AW'(32'h301), AW'(32'h302), 3'd0, 1'b0);
    push(AW'(32'h302), AW'(32'h303), 3'd0, 1'b0);
    resolve(3'd1, 1'b1, AW'(32'h180));
    check("mp_upd", 64'(update_en), 64'(1));
    check("mp_mis", 64'(mis_pdc), 64'(3'b101));
    check("mp_redirect", 64'(redirect_valid), 64'(1));
    check("mp_redirect_pc", 64'(redirect_pc), 64'(32'h180));
    check("mp_taken_real", 64'(taken_real), 64'(1));
    step();
    check("mp_redirect_pulse", 64'(redirect_valid), 64'(0));
    push(AW'(32'h500), AW'(32'h501), 3'd0, 1'b0);
    resolve(3'd0, 1'b0, '0);
    check("mp_next_head", 64'(pc_ex), 64'(32'h500));
    resolve(3'd0, 1'b0, '0);
    check("mp_empty_after", 64'(update_en), 64'(0));

    // ---- sequential PC wraps at the top of the address space -----------------
    do_reset();
    push(AW'(32'h3FFF_FFFF), AW'(32'h12345), 3'd0, 1'b0);
    resolve(3'd0, 1'b0, '0);
    check("wrap_npc_ex", 64'(npc_ex), 64'(0));
    check("wrap_mis", 64'(mis_pdc), 64'(3'b100));
    check("wrap_redirect_pc", 64'(redirect_pc), 64'(0));
    step();
    push(AW'(32'h3FFF_FFFF), AW'(32'h0), 3'd0, 1'b0);
    resolve(3'd0, 1'b0, '0);
    check("wrap_ok_mis", 64'(mis_pdc), 64'(3'b000));
    check("wrap_ok_redirect", 64'(redirect_valid), 64'(0));

    // ---- push in the mispredicting cycle is dropped --------------------------
    do_reset();
    push(AW'(32'h10), AW'(32'h11), 3'd0, 1'b0);
    push(AW'(32'h20), AW'(32'h21), 3'd0, 1'b0);
    push_valid = 1'b1;
    push_pc    = AW'(32'h30);
    push_npc   = AW'(32'h31);
    resolve(3'd0, 1'b1, AW'(32'h50));
    push_valid = 1'b0;
    check("drop_mis", 64'(mis_pdc), 64'(3'b101));
    check("drop_redirect_pc", 64'(redirect_pc), 64'(32'h50));
    resolve(3'd0, 1'b0, '0);
    check("drop_empty", 64'(update_en), 64'(0));

    // ---- chooser, RET kind and pass-through metadata --------------------------
    do_reset();
    res_ret_pc = AW'(32'h777);
    push_full(AW'(32'h600), AW'(32'h640), 3'd4, 1'b1, HW'(14'h2A5), 2'b01, 8'b1000_0000);
    push_full(AW'(32'h640), AW'(32'h641), 3'd0, 1'b0, HW'(14'h011), 2'b10, 8'b0010_0000);
    push_full(AW'(32'h641), AW'(32'h642), 3'd0, 1'b0, HW'(14'h001), 2'b01, 8'b0000_0000);
    resolve(3'd4, 1'b1, AW'(32'h640));
    check("ch_g_agree", 64'(choice_real), 64'(2'b11));
    check("ch_mis", 64'(mis_pdc), 64'(3'b000));
    check("ch_bh", 64'(bh_ex), 64'(14'h2A5));
    check("ch_pdch", 64'(out_pdch), 64'(8'h80));
    check("ch_choice_pdc", 64'(choice_pdc_ex), 64'(2'b01));
    check("ch_ret_pc", 64'(ret_pc_ex), 64'(32'h777));
    check("ch_kind", 64'(kind_ex), 64'(4));
    resolve(3'd0, 1'b0, AW'(32'h641));
    // pdch[7]=0 matches not-taken -> chooser bit 1; kind not RET
    check("ch_g_agree_nt", 64'(choice_real), 64'(2'b01));
    resolve(3'd0, 1'b1, AW'(32'h642));
    // taken: pdch[7]=0 and pdch[5]=0 both disagree -> keep stored choice[0]=1
    check("ch_keep", 64'(choice_real), 64'(2'b01));
    check("ch_keep_mis", 64'(mis_pdc), 64'(3'b001));
    do_reset();
    push_full(AW'(32'h700), AW'(32'h701), 3'd0, 1'b0, '0, 2'b01, 8'b0010_0000);
    resolve(3'd0, 1'b1, AW'(32'h701));
    // taken: pdch[7]=0 disagrees, pdch[5]=1 agrees -> 0
    check("ch_b_agree", 64'(choice_real), 64'(2'b00));

    // ---- underflow is sticky until reset ------------------------------------
    do_reset();
    resolve(3'd0, 1'b0, '0);
    check("uf_upd", 64'(update_en), 64'(0));
    check("uf_err", 64'(err_underflow), 64'(1));
    step();
    step();
    check("uf_sticky", 64'(err_underflow), 64'(1));
    do_reset();
    check("uf_reset_clears", 64'(err_underflow), 64'(0));

    // ---- flush beats a concurrent pop ----------------------------------------
    for (int i = 0; i < 4; i++) push(AW'(32'h900 + i), AW'(32'h0), 3'd0, 1'b0);
    flush_in = 1'b1;
    resolve(3'd0, 1'b1, AW'(32'h123));
    flush_in = 1'b0;
    check("fl_upd", 64'(update_en), 64'(0));
    check("fl_redirect", 64'(redirect_valid), 64'(0));
    check("fl_ready", 64'(push_ready), 64'(1));
    resolve(3'd0, 1'b0, '0);
    check("fl_empty", 64'(update_en), 64'(0));

    // ---- pending registered outputs survive a flush the next cycle ----------
    do_reset();
    push(AW'(32'hA00), AW'(32'hA01), 3'd0, 1'b0);
    push(AW'(32'hB00), AW'(32'hB01), 3'd0, 1'b0);
    resolve(3'd0, 1'b0, '0);
    flush_in = 1'b1;
    check("fl_pending_upd", 64'(update_en), 64'(1));
    check("fl_pending_pc", 64'(pc_ex), 64'(32'hA00));
    step();
    flush_in = 1'b0;
    check("fl_pending_hold", 64'(pc_ex), 64'(32'hA00));
    resolve(3'd0, 1'b0, '0);
    check("fl_after_empty", 64'(update_en), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Backstop so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
